draw_scheduler: RTL and testbench
=================================

// Module: draw_scheduler
// PURPOSE
//  Per-frame sequencer sharing the single VGA framebuffer write port between N sprite drawers
//  (ship, asteroids, bullets; each a draw_sprite-based block).
//  On each frame tick: erase pass redraws every sprite drawn last frame at its old position in
//  BG_COLOR. Draw pass then draws every enabled sprite at its newly latched position.
//  Sits between game logic (positions/enables) and the VGA adapter.
// PARAMETERS
//  N_REQ     4      number of drawer clients (index 0 = highest priority / first served)
//  BG_COLOR  3'b000 colour forced onto vga_color during erase pass
//  TIMEOUT   2047   max cycles in a WAIT state before client is abandoned
// PORTS
//  clk          in   1         system clock
//  reset        in   1         synchronous, active-high reset
//  frame_tick   in   1         1-cycle pulse, start of frame
//  req_en       in   N_REQ     client i is drawn this frame
//  pos_x_in     in   10*N_REQ  new x per client (slice i = [10i+9:10i])
//  pos_y_in     in   10*N_REQ  new y per client
//  drw_plot     out  N_REQ     1-cycle start pulse to the granted client's plot input
//  drw_x_pos    out  10        position to the granted client; held stable for whole grant
//  drw_y_pos    out  10
//  drw_x        in   10*N_REQ  client pixel x
//  drw_y        in   10*N_REQ  client pixel y
//  drw_we       in   N_REQ     client writeEn
//  drw_color    in   3*N_REQ   client colour
//  drw_done     in   N_REQ     client draw_done
//  vga_x/vga_y  out  10/10     muxed pixel coordinate
//  vga_we       out  1         muxed write enable
//  vga_color    out  3         muxed colour (BG_COLOR in erase pass)
//  busy         out  1         high from frame accept until DONE
//  frame_overrun out 1         1-cycle pulse: frame_tick arrived while busy
//  timeout_err  out  1         sticky; set on any client timeout, cleared only by reset
// BEHAVIOUR
//  - Reset: state IDLE; drw_plot=0, vga_we=0, busy=0, frame_overrun=0, timeout_err=0.
//    drw_x_pos/drw_y_pos=0. All drawn[] flags and old_pos cleared; no erase on first frame.
//  - FSM: IDLE -> LATCH -> ERASE_SEL -> ERASE_START -> ERASE_WAIT -> ... -> DRAW_SEL -> DRAW_START
//    -> DRAW_WAIT -> ... -> DONE -> IDLE.
//  - IDLE: frame_tick -> LATCH. Cycle after the tick: new_pos[i]<=pos_in[i], en_q<=req_en, busy<=1.
//  - ERASE_SEL: scan idx from 0 upward for the next client with drawn[i]=1. None left -> DRAW_SEL with idx=0.
//    Scan costs 1 cycle per index.
//  - ERASE_START: drw_x/y_pos<=old_pos[idx]; drw_plot[idx]=1 for exactly 1 cycle -> ERASE_WAIT.
//  - DRAW_SEL/DRAW_START: same scan/start sequence over en_q[i]=1, using new_pos[idx].
//  - WAIT states: vga_x/y/we = client idx outputs (combinational, 0 latency).
//    vga_color = BG_COLOR in ERASE_WAIT, drw_color[idx] in DRAW_WAIT.
//    Outside WAIT states: vga_we=0.
//  - Completion: drw_done[idx] is ignored during the first WAIT cycle (stale level from the previous
//    grant). It is accepted from the 2nd cycle on.
//    On accept: idx++ and return to the SEL state.
//    Draw pass accept also sets drawn[idx]=1 and old_pos[idx]<=new_pos[idx].
//  - Timeout: wait counter reaches TIMEOUT without done -> timeout_err<=1, abandon client, idx++.
//    Draw pass also sets drawn[idx]=0.
//  - Erase pass accept/timeout clears drawn[idx].
//  - DONE: busy<=0 -> IDLE. A frame_tick in the DONE cycle is treated as overrun.
//  - frame_tick while busy: ignored; frame_overrun=1 in the following cycle; current frame continues.
//  - Clients with req_en low: skipped in draw pass. If drawn last frame they are still erased
//    (sprite disappears).
//  - reset mid-frame: immediate return to IDLE. drw_plot/vga_we low next cycle. drawn[] cleared.
//  - Only one client granted at any time; drw_plot is one-hot or zero.
// TESTING
//  1. N_REQ=2, first tick, en=2'b11, pos0=(10,20), pos1=(100,50), clients done 40 cyc after plot
//     -> no erase; plot0 then plot1.
//     vga_we follows client0 then client1; colours pass through; busy falls after client1 done.
//  2. Second tick, pos0=(12,20) -> erase client0 at (10,20) and client1 at (100,50) with
//     vga_color=000, then draw at new positions.
//  3. Client1 req_en dropped on frame 3 -> client1 erased at old pos, no draw plot;
//     frame 4 has no erase for client1.
//  4. Client0 never asserts done -> after 2047 WAIT cycles timeout_err=1, client1 still served;
//     next frame client0 not erased.
//  5. frame_tick pulsed mid draw pass -> frame_overrun pulses 1 cycle; sequence uninterrupted;
//     next tick accepted after IDLE.
//  6. reset asserted during DRAW_WAIT -> next cycle vga_we=0, drw_plot=0, busy=0;
//     following frame performs no erase.

Source files
------------

// File: rtl/draw_scheduler.sv
// Per-frame erase/draw sequencer sharing one framebuffer write port
// between N_REQ sprite drawer clients.
`timescale 1ns/1ps
module draw_scheduler #(
  parameter int         N_REQ    = 4,
  parameter logic [2:0] BG_COLOR = 3'b000,
  parameter int         TIMEOUT  = 2047
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [N_REQ-1:0]    req_en,
  input  logic [10*N_REQ-1:0] pos_x_in,
  input  logic [10*N_REQ-1:0] pos_y_in,
  output logic [N_REQ-1:0]    drw_plot,
  output logic [9:0]          drw_x_pos,
  output logic [9:0]          drw_y_pos,
  input  logic [10*N_REQ-1:0] drw_x,
  input  logic [10*N_REQ-1:0] drw_y,
  input  logic [N_REQ-1:0]    drw_we,
  input  logic [3*N_REQ-1:0]  drw_color,
  input  logic [N_REQ-1:0]    drw_done,
  output logic [9:0]          vga_x,
  output logic [9:0]          vga_y,
  output logic                vga_we,
  output logic [2:0]          vga_color,
  output logic                busy,
  output logic                frame_overrun,
  output logic                timeout_err
);

  localparam int IW = $clog2(N_REQ + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE,
    LATCH,
    ERASE_SEL,
    ERASE_START,
    ERASE_WAIT,
    DRAW_SEL,
    DRAW_START,
    DRAW_WAIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]    idx, idx_n;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] drawn;
  logic [N_REQ-1:0] en_q;
  logic [9:0]       new_x [N_REQ];
  logic [9:0]       new_y [N_REQ];
  logic [9:0]       old_x [N_REQ];
  logic [9:0]       old_y [N_REQ];

  logic       sel_drawn, sel_en;
  logic [9:0] sel_ox, sel_oy, sel_nx, sel_ny;
  logic [9:0] cli_x, cli_y;
  logic       cli_we, cli_done;
  logic [2:0] cli_color;
  logic       last, accept, tmo, in_wait;

  always_comb begin
    sel_drawn = 1'b0;
    sel_en    = 1'b0;
    sel_ox    = '0;
    sel_oy    = '0;
    sel_nx    = '0;
    sel_ny    = '0;
    cli_x     = '0;
    cli_y     = '0;
    cli_we    = 1'b0;
    cli_done  = 1'b0;
    cli_color = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx == IW'(i)) begin
        sel_drawn = drawn[i];
        sel_en    = en_q[i];
        sel_ox    = old_x[i];
        sel_oy    = old_y[i];
        sel_nx    = new_x[i];
        sel_ny    = new_y[i];
        cli_x     = drw_x[10*i +: 10];
        cli_y     = drw_y[10*i +: 10];
        cli_we    = drw_we[i];
        cli_done  = drw_done[i];
        cli_color = drw_color[3*i +: 3];
      end
    end
  end

  // done is stale during the first wait cycle (cnt == 0)
  assign last    = (idx == IW'(N_REQ));
  assign accept  = cli_done && (cnt != '0);
  assign tmo     = !accept && (cnt == CW'(TIMEOUT - 1));
  assign in_wait = (state == ERASE_WAIT) || (state == DRAW_WAIT);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        if (frame_tick) state_n = LATCH;
      end
      LATCH: begin
        idx_n   = '0;
        state_n = ERASE_SEL;
      end
      ERASE_SEL: begin
        if (last) begin
          idx_n   = '0;
          state_n = DRAW_SEL;
        end else if (sel_drawn) begin
          state_n = ERASE_START;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      ERASE_START: state_n = ERASE_WAIT;
      ERASE_WAIT: begin
        if (accept || tmo) begin
          idx_n   = idx + IW'(1);
          state_n = ERASE_SEL;
        end
      end
      DRAW_SEL: begin
        if (last) begin
          state_n = DONE;
        end else if (sel_en) begin
          state_n = DRAW_START;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      DRAW_START: state_n = DRAW_WAIT;
      DRAW_WAIT: begin
        if (accept || tmo) begin
          idx_n   = idx + IW'(1);
          state_n = DRAW_SEL;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    drw_plot = '0;
    if (state == ERASE_START || state == DRAW_START) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (idx == IW'(i)) drw_plot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    vga_x     = '0;
    vga_y     = '0;
    vga_we    = 1'b0;
    vga_color = '0;
    if (in_wait) begin
      vga_x     = cli_x;
      vga_y     = cli_y;
      vga_we    = cli_we;
      vga_color = (state == ERASE_WAIT) ? BG_COLOR : cli_color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      drawn         <= '0;
      en_q          <= '0;
      busy          <= 1'b0;
      frame_overrun <= 1'b0;
      timeout_err   <= 1'b0;
      drw_x_pos     <= '0;
      drw_y_pos     <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        new_x[i] <= '0;
        new_y[i] <= '0;
        old_x[i] <= '0;
        old_y[i] <= '0;
      end
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      frame_overrun <= frame_tick && (state != IDLE);

      if (state == IDLE && frame_tick) begin
        busy <= 1'b1;
        en_q <= req_en;
        for (int i = 0; i < N_REQ; i++) begin
          new_x[i] <= pos_x_in[10*i +: 10];
          new_y[i] <= pos_y_in[10*i +: 10];
        end
      end
      if (state == DONE) busy <= 1'b0;

      if (state == ERASE_START || state == DRAW_START) begin
        cnt <= '0;
      end else if (in_wait) begin
        cnt <= cnt + CW'(1);
      end

      // position loaded ahead of the plot pulse so it is stable all grant
      if (state == ERASE_SEL && !last && sel_drawn) begin
        drw_x_pos <= sel_ox;
        drw_y_pos <= sel_oy;
      end
      if (state == DRAW_SEL && !last && sel_en) begin
        drw_x_pos <= sel_nx;
        drw_y_pos <= sel_ny;
      end

      if (in_wait && tmo) timeout_err <= 1'b1;

      for (int i = 0; i < N_REQ; i++) begin
        if (idx == IW'(i)) begin
          if (state == ERASE_WAIT && (accept || tmo)) begin
            drawn[i] <= 1'b0;
          end
          if (state == DRAW_WAIT && accept) begin
            drawn[i] <= 1'b1;
            old_x[i] <= new_x[i];
            old_y[i] <= new_y[i];
          end
          if (state == DRAW_WAIT && tmo) begin
            drawn[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: behavioural sprite clients plus a
// frame-level model of which sprites get erased and drawn.
`timescale 1ns/1ps
module tb_draw_scheduler;

  localparam int N = 2;

  typedef struct {
    int c;
    int x;
    int y;
  } ev_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_tick;
  logic [N-1:0]    req_en;
  logic [10*N-1:0] pos_x_in;
  logic [10*N-1:0] pos_y_in;
  logic [N-1:0]    drw_plot;
  logic [9:0]      drw_x_pos;
  logic [9:0]      drw_y_pos;
  logic [10*N-1:0] drw_x;
  logic [10*N-1:0] drw_y;
  logic [3*N-1:0]  drw_color;
  logic [9:0]      vga_x;
  logic [9:0]      vga_y;
  logic            vga_we;
  logic [2:0]      vga_color;
  logic            busy;
  logic            frame_overrun;
  logic            timeout_err;

  logic [N-1:0] c_we   = '0;
  logic [N-1:0] c_done = '0;
  logic [9:0]   cx [N] = '{default: '0};
  logic [9:0]   cy [N] = '{default: '0};
  logic [2:0]   c_col [N];
  int           c_len [N];
  bit           c_hang [N];
  bit           pend [N] = '{default: 1'b0};
  int           cc [N];
  logic [9:0]   px [N];
  logic [9:0]   py [N];

  bit  m_drawn [N];
  int  m_ox [N];
  int  m_oy [N];
  bit  m_terr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign drw_x[10*g +: 10]    = cx[g];
    assign drw_y[10*g +: 10]    = cy[g];
    assign drw_color[3*g +: 3]  = c_col[g];
  end

  draw_scheduler #(.N_REQ(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .req_en       (req_en),
    .pos_x_in     (pos_x_in),
    .pos_y_in     (pos_y_in),
    .drw_plot     (drw_plot),
    .drw_x_pos    (drw_x_pos),
    .drw_y_pos    (drw_y_pos),
    .drw_x        (drw_x),
    .drw_y        (drw_y),
    .drw_we       (c_we),
    .drw_color    (drw_color),
    .drw_done     (c_done),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_we       (vga_we),
    .vga_color    (vga_color),
    .busy         (busy),
    .frame_overrun(frame_overrun),
    .timeout_err  (timeout_err)
  );

  // Sprite clients: done stays high (stale) into the first wait cycle,
  // then c_len pixels are written in a row, then done rises again.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (drw_plot[i]) begin
        pend[i] = 1'b1;
        cc[i]   = 0;
        px[i]   = drw_x_pos;
        py[i]   = drw_y_pos;
      end else if (pend[i]) begin
        cc[i]++;
        c_done[i] = 1'b0;
        if (cc[i] <= c_len[i]) begin
          c_we[i] = 1'b1;
          cx[i]   = px[i] + 10'(cc[i] - 1);
          cy[i]   = py[i];
        end else begin
          c_we[i] = 1'b0;
          if (!c_hang[i]) begin
            c_done[i] = 1'b1;
            pend[i]   = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [1:0] en,
                           input int x0, input int y0,
                           input int x1, input int y1,
                           input int ovr_at);
    ev_t  exq [$];
    ev_t  obq [$];
    ev_t  e;
    int   n_er, cur, hp, nx [N], ny [N];
    bit   fin;
    logic pt, pb, pterr;
    logic [2:0] ecol;
    nx[0] = x0; ny[0] = y0;
    nx[1] = x1; ny[1] = y1;
    for (int i = 0; i < N; i++) begin
      if (m_drawn[i]) begin
        e.c = i; e.x = m_ox[i]; e.y = m_oy[i];
        exq.push_back(e);
      end
    end
    n_er = exq.size();
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        e.c = i; e.x = nx[i]; e.y = ny[i];
        exq.push_back(e);
      end
    end
    req_en     = en;
    pos_x_in   = {10'(x1), 10'(x0)};
    pos_y_in   = {10'(y1), 10'(y0)};
    frame_tick = 1'b1;
    pt = 1'b1; pb = busy; pterr = timeout_err;
    cur = -1; hp = -1; fin = 1'b0;
    for (int cyc = 1; cyc <= 10000; cyc++) begin
      @(posedge clk); #1;
      chk("overrun", frame_overrun, pt && pb);
      if (cyc == 1) chk("busy_rise", busy, 1);
      chk("plot_onehot", $onehot0(drw_plot), 1);
      if (drw_plot != '0) begin
        cur = drw_plot[1] ? 1 : 0;
        e.c = cur; e.x = drw_x_pos; e.y = drw_y_pos;
        obq.push_back(e);
        if (c_hang[cur] && hp < 0) hp = cyc;
      end
      if (cur < 0) begin
        chk("we_idle", vga_we, 0);
      end else begin
        chk("we_mux", vga_we, c_we[cur]);
        if (vga_we) begin
          ecol = (obq.size() <= n_er) ? 3'b000 : c_col[cur];
          chk("vga_x", vga_x, cx[cur]);
          chk("vga_y", vga_y, cy[cur]);
          chk("vga_color", vga_color, ecol);
        end
      end
      if (timeout_err && !pterr) chk("timeout_cycles", cyc - hp, 2048);
      frame_tick = (cyc == ovr_at);
      pt = frame_tick; pb = busy; pterr = timeout_err;
      if (!busy && cyc > 1) begin
        fin = 1'b1;
        break;
      end
    end
    chk("frame_end", fin, 1);
    chk("ev_count", obq.size(), exq.size());
    for (int k = 0; k < exq.size() && k < obq.size(); k++) begin
      chk("ev_client", obq[k].c, exq[k].c);
      chk("ev_x", obq[k].x, exq[k].x);
      chk("ev_y", obq[k].y, exq[k].y);
    end
    for (int k = 0; k < exq.size(); k++) begin
      e = exq[k];
      if (k < n_er) begin
        m_drawn[e.c] = 1'b0;
        if (c_hang[e.c]) m_terr = 1'b1;
      end else if (c_hang[e.c]) begin
        m_drawn[e.c] = 1'b0;
        m_terr = 1'b1;
      end else begin
        m_drawn[e.c] = 1'b1;
        m_ox[e.c] = e.x;
        m_oy[e.c] = e.y;
      end
    end
    chk("timeout_err", timeout_err, m_terr);
  endtask

  initial begin
    int np, w;
    reset = 1'b1; frame_tick = 1'b0; req_en = '0;
    pos_x_in = '0; pos_y_in = '0;
    c_col[0] = 3'b101; c_col[1] = 3'b011;
    for (int i = 0; i < N; i++) begin
      c_len[i] = 40; c_hang[i] = 1'b0;
      m_drawn[i] = 1'b0; m_ox[i] = 0; m_oy[i] = 0;
    end
    m_terr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_we", vga_we, 0);
    chk("rst_plot", drw_plot, 0);
    chk("rst_ovr", frame_overrun, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_xpos", drw_x_pos, 0);
    chk("rst_ypos", drw_y_pos, 0);

    run_frame(2'b11, 10, 20, 100, 50, -1);
    run_frame(2'b11, 12, 20, 100, 50, -1);
    run_frame(2'b01, 14, 22, 100, 50, -1);
    run_frame(2'b01, 16, 24, 100, 50, -1);
    c_hang[0] = 1'b1;
    run_frame(2'b11, 18, 26, 110, 60, -1);
    c_hang[0] = 1'b0;
    run_frame(2'b11, 20, 28, 120, 70, 100);

    req_en = 2'b11;
    pos_x_in = {10'd130, 10'd30};
    pos_y_in = {10'd80, 10'd40};
    frame_tick = 1'b1;
    np = 0; w = 0;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
      if (drw_plot != '0) np++;
      if (np == 3) begin
        w++;
        if (w == 6) break;
      end
    end
    chk("reset_point", w, 6);
    chk("pre_reset_we", vga_we, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_we", vga_we, 0);
    chk("mid_rst_plot", drw_plot, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_terr", timeout_err, 0);
    for (int i = 0; i < N; i++) m_drawn[i] = 1'b0;
    m_terr = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    run_frame(2'b11, 40, 50, 140, 90, -1);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        c_len[i] = $urandom_range(0, 6);
        c_col[i] = 3'($urandom_range(0, 7));
      end
      run_frame(2'($urandom_range(0, 3)),
                $urandom_range(0, 639), $urandom_range(0, 479),
                $urandom_range(0, 639), $urandom_range(0, 479),
                ($urandom_range(0, 1) == 1) ? 3 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
